// File: rtl/datapath_ctrl_seq.sv
// -----------------------------------------------------------------------------
// datapath_ctrl_seq
//
// Control-step sequencer for the register-file / Z-register datapath. It takes
// one register-transfer instruction at a time (LOAD, MOVE, ADD, NOP) and steps
// through the T-states of that instruction, driving the bus/strobe controls
// that the DataPath needs. Every output is decoded from the registered state
// plus the operand fields latched when the instruction was accepted.
//
// Optional feature: define DATAPATH_CTRL_PERF_EN to add the retired_cnt output
// (16-bit count of DONE cycles, wrapping, cleared by reset).
//
// Parameters
//   NREG    number of general registers driven (R0..R(NREG-1))
//   RSEL_W  width of the register select fields; 2**RSEL_W >= NREG
//
// Ports
//   clock        rising-edge system clock
//   clear        asynchronous active-low reset
//   start        instruction request, sampled only while ready=1
//   opcode[1:0]  00 LOAD (Mdatain->Rd), 01 MOVE (Ra->Z->Rd),
//                10 ADD (Ra+Rb->Z->Rd), 11 NOP
//   ra, rb, rd   source A, source B (ADD only) and destination indices
//   ready        high only in IDLE
//   done         one-cycle completion pulse (DONE state)
//   Rout, Rin    one-hot register-to-bus / bus-to-register enables
//   Yin          load Y from bus
//   Zin          load Z from ALU
//   Zlowout      drive Z low word onto bus
//   MDRout       drive Mdatain onto bus
//   alu_add      1 = ALU computes Y+bus, 0 = ALU passes bus through
//   retired_cnt  (DATAPATH_CTRL_PERF_EN only) retired-instruction counter
// -----------------------------------------------------------------------------
module datapath_ctrl_seq #(
    parameter int NREG   = 4,
    parameter int RSEL_W = 2
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [1:0]        opcode,
    input  logic [RSEL_W-1:0] ra,
    input  logic [RSEL_W-1:0] rb,
    input  logic [RSEL_W-1:0] rd,
    output logic              ready,
    output logic              done,
    output logic [NREG-1:0]   Rout,
    output logic [NREG-1:0]   Rin,
    output logic              Yin,
    output logic              Zin,
    output logic              Zlowout,
    output logic              MDRout,
    output logic              alu_add
`ifdef DATAPATH_CTRL_PERF_EN
    ,
    output logic [15:0]       retired_cnt
`endif
);

    // Opcodes
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_MOVE = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;

    // Control steps
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LD   = 3'd1;
    localparam logic [2:0] S_TA   = 3'd2;
    localparam logic [2:0] S_TB   = 3'd3;
    localparam logic [2:0] S_MV   = 3'd4;
    localparam logic [2:0] S_WB   = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [1:0]        opcode_q;
    logic [RSEL_W-1:0] ra_q;
    logic [RSEL_W-1:0] rb_q;
    logic [RSEL_W-1:0] rd_q;

    logic accept;
    assign accept = (state_q == S_IDLE) && start;

    // Indices at or above NREG decode to all-zero, so an out-of-range source
    // leaves the bus undriven and an out-of-range destination discards the write.
    function automatic logic [NREG-1:0] onehot(input logic [RSEL_W-1:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            if (idx == RSEL_W'(i)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Next-state logic
    // NOTE: every variable written in a combinational block gets a default
    // before the case statement; a path that skips an assignment infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (opcode)
                        OP_LOAD: state_d = S_LD;
                        OP_MOVE: state_d = S_MV;
                        OP_ADD:  state_d = S_TA;
                        default: state_d = S_DONE;   // NOP
                    endcase
                end
            end
            S_LD:    state_d = S_DONE;
            S_TA:    state_d = S_TB;
            S_TB:    state_d = S_WB;
            S_MV:    state_d = S_WB;
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and operand latch. The operand fields are reset as well so that a
    // sequence aborted by clear leaves no stale index behind.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same edge, independent of statement order.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rd_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                opcode_q <= opcode;
                ra_q     <= ra;
                rb_q     <= rb;
                rd_q     <= rd;
            end
        end
    end

    // Output decode: one driver on the bus per state (Rout, MDRout or Zlowout),
    // which keeps the bus-exclusivity invariant structural.
    always_comb begin
        ready   = 1'b0;
        done    = 1'b0;
        Rout    = '0;
        Rin     = '0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        alu_add = 1'b0;
        case (state_q)
            S_IDLE: ready = 1'b1;
            S_LD: begin
                MDRout = 1'b1;
                Rin    = onehot(rd_q);
            end
            S_TA: begin
                Rout = onehot(ra_q);
                Yin  = 1'b1;
            end
            S_TB: begin
                Rout    = onehot(rb_q);
                alu_add = (opcode_q == OP_ADD);   // TB is only reached by ADD
                Zin     = 1'b1;
            end
            S_MV: begin
                Rout = onehot(ra_q);              // ALU passes the bus into Z
                Zin  = 1'b1;
            end
            S_WB: begin
                Zlowout = 1'b1;
                Rin     = onehot(rd_q);
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

`ifdef DATAPATH_CTRL_PERF_EN
    // Retired-instruction counter; NOPs count, and the add wraps naturally.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            retired_cnt <= '0;
        end else if (state_q == S_DONE) begin
            retired_cnt <= retired_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_datapath_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_datapath_ctrl_seq
//
// Directed bench for datapath_ctrl_seq. For each instruction the expected
// per-cycle control outputs are pushed to a scoreboard queue and popped one per
// clock as the sequencer steps. A small behavioural DataPath (register file,
// Y, Z, bus) is driven by the sequencer strobes so register contents can be
// checked against hand-computed values. A second instance with NREG=3 covers
// the out-of-range destination index.
// -----------------------------------------------------------------------------
module tb_datapath_ctrl_seq;

    localparam int NREG   = 4;
    localparam int RSEL_W = 2;

    typedef enum int {T_IDLE, T_LD, T_TA, T_TB, T_MV, T_WB, T_DONE} tstep_t;

    typedef struct packed {
        logic       ready;
        logic       done;
        logic [3:0] rout;
        logic [3:0] rin;
        logic       yin;
        logic       zin;
        logic       zlo;
        logic       mdr;
        logic       add;
    } outs_t;

    logic              clock = 1'b0;
    logic              clear;
    logic              start;
    logic              start3;
    logic [1:0]        opcode;
    logic [RSEL_W-1:0] ra, rb, rd;

    logic              ready, done, yin, zin, zlowout, mdrout, alu_add;
    logic [NREG-1:0]   rout, rin;

    logic              ready3, done3, yin3, zin3, zlo3, mdr3, add3;
    logic [2:0]        rout3, rin3;

`ifdef DATAPATH_CTRL_PERF_EN
    logic [15:0]       rc, rc3;
    int                perf_exp = 0;
`endif

    int errors = 0;
    int checks = 0;

    outs_t exp_q[$];
    string tag_q[$];

    // Behavioural DataPath driven by the sequencer strobes
    logic [31:0] mdatain;
    logic [31:0] r [4] = '{default: 32'h0};
    logic [31:0] y = 32'h0;
    logic [31:0] z = 32'h0;
    logic [31:0] rbus;
    logic [31:0] bus;

    datapath_ctrl_seq #(.NREG(NREG), .RSEL_W(RSEL_W)) dut (
        .clock   (clock),
        .clear   (clear),
        .start   (start),
        .opcode  (opcode),
        .ra      (ra),
        .rb      (rb),
        .rd      (rd),
        .ready   (ready),
        .done    (done),
        .Rout    (rout),
        .Rin     (rin),
        .Yin     (yin),
        .Zin     (zin),
        .Zlowout (zlowout),
        .MDRout  (mdrout),
        .alu_add (alu_add)
`ifdef DATAPATH_CTRL_PERF_EN
        ,
        .retired_cnt (rc)
`endif
    );

    datapath_ctrl_seq #(.NREG(3), .RSEL_W(RSEL_W)) dut3 (
        .clock   (clock),
        .clear   (clear),
        .start   (start3),
        .opcode  (opcode),
        .ra      (ra),
        .rb      (rb),
        .rd      (rd),
        .ready   (ready3),
        .done    (done3),
        .Rout    (rout3),
        .Rin     (rin3),
        .Yin     (yin3),
        .Zin     (zin3),
        .Zlowout (zlo3),
        .MDRout  (mdr3),
        .alu_add (add3)
`ifdef DATAPATH_CTRL_PERF_EN
        ,
        .retired_cnt (rc3)
`endif
    );

    always #5 clock = ~clock;

    always_comb begin
        rbus = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (rout[i]) rbus = rbus | r[i];
        end
    end

    assign bus = mdrout ? mdatain : (zlowout ? z : rbus);

    always @(posedge clock) begin
        if (yin) y <= bus;
        if (zin) z <= alu_add ? (y + bus) : bus;
        for (int i = 0; i < 4; i++) begin
            if (rin[i]) r[i] <= bus;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] oh(input logic [1:0] idx);
        logic [3:0] one;
        one = 4'b0001;
        return one << idx;
    endfunction

    function automatic outs_t expect_step(input tstep_t st, input logic [1:0] a,
                                          input logic [1:0] b, input logic [1:0] d);
        outs_t e;
        e = '0;
        case (st)
            T_IDLE: e.ready = 1'b1;
            T_LD:   begin e.mdr = 1'b1; e.rin = oh(d); end
            T_TA:   begin e.rout = oh(a); e.yin = 1'b1; end
            T_TB:   begin e.rout = oh(b); e.add = 1'b1; e.zin = 1'b1; end
            T_MV:   begin e.rout = oh(a); e.zin = 1'b1; end
            T_WB:   begin e.zlo = 1'b1; e.rin = oh(d); end
            T_DONE: e.done = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic outs_t observe();
        outs_t o;
        o = '{ready, done, rout, rin, yin, zin, zlowout, mdrout, alu_add};
        return o;
    endfunction

    task automatic push(input string tag, input tstep_t st,
                        input logic [1:0] a, input logic [1:0] b, input logic [1:0] d);
        exp_q.push_back(expect_step(st, a, b, d));
        tag_q.push_back($sformatf("%s.%s", tag, st.name()));
    endtask

    task automatic check_outs(input string tag, input outs_t obs, input outs_t e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%b required=%b (rdy,done,rout,rin,yin,zin,zlo,mdr,add)",
                   tag, obs, e);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h required=%h", tag, obs, e);
        end
    endtask

    // One clock: sample #1 after the edge, check bus exclusivity, then pop
    // and compare the scoreboard entry for this cycle if one is pending.
    task automatic tick();
        int drivers;
        outs_t e;
        string t;
        @(posedge clock);
        #1;
        drivers = $countones(rout) + int'(mdrout) + int'(zlowout);
        checks++;
        assert (drivers <= 1 && $onehot0(rout) && $onehot0(rin)) else begin
            errors++;
            $error("FAIL bus_excl observed drivers=%0d rout=%b rin=%b required <=1 one-hot",
                   drivers, rout, rin);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_outs(t, observe(), e);
        end
    endtask

    // Issue one instruction from an IDLE cycle and step until its scoreboard
    // entries are consumed. noise scrambles start/opcode/operands while busy;
    // hold leaves start high afterwards for a back-to-back accept.
    task automatic run_instr(input string tag, input logic [1:0] op, input logic [1:0] a,
                             input logic [1:0] b, input logic [1:0] d,
                             input bit noise, input bit hold);
        opcode = op; ra = a; rb = b; rd = d; start = 1'b1;
        case (op)
            2'b00: begin push(tag, T_LD, a, b, d); end
            2'b01: begin push(tag, T_MV, a, b, d); push(tag, T_WB, a, b, d); end
            2'b10: begin
                push(tag, T_TA, a, b, d); push(tag, T_TB, a, b, d);
                push(tag, T_WB, a, b, d);
            end
            default: ;
        endcase
        push(tag, T_DONE, a, b, d);
        push(tag, T_IDLE, a, b, d);
        while (exp_q.size() > 0) begin
            tick();
            if (exp_q.size() > 0) begin
                if (noise) begin
                    start  = 1'($urandom_range(1));
                    opcode = 2'($urandom_range(3));
                    ra     = 2'($urandom_range(3));
                    rd     = 2'($urandom_range(3));
                end else begin
                    start = 1'b0;
                end
            end else begin
                start = hold;
            end
        end
`ifdef DATAPATH_CTRL_PERF_EN
        perf_exp++;
        check32({tag, ".retired_cnt"}, {16'h0, rc}, perf_exp);
`endif
    endtask

    initial begin
        clear = 1'b0; start = 1'b0; start3 = 1'b0;
        opcode = 2'b00; ra = '0; rb = '0; rd = '0;
        mdatain = 32'h0;

        // Reset state
        #12;
        check_outs("reset", observe(), expect_step(T_IDLE, 0, 0, 0));
        clear = 1'b1;

        // LOAD R0 <- 0x10, LOAD R1 <- 0x20
        mdatain = 32'h10;
        run_instr("load_r0", 2'b00, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        check32("r0", r[0], 32'h10);
        mdatain = 32'h20;
        run_instr("load_r1", 2'b00, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0);
        check32("r1", r[1], 32'h20);
        mdatain = 32'hDEAD_BEEF;

        // ADD aborted by clear while in TB: no Z load, no write-back
        opcode = 2'b10; ra = 2'd0; rb = 2'd1; rd = 2'd2; start = 1'b1;
        push("abort", T_TA, 2'd0, 2'd1, 2'd2);
        push("abort", T_TB, 2'd0, 2'd1, 2'd2);
        tick();
        start = 1'b0;
        tick();
        clear = 1'b0;
        #1;
        check_outs("abort.async", observe(), expect_step(T_IDLE, 0, 0, 0));
        push("abort.held", T_IDLE, 0, 0, 0);
        tick();
        clear = 1'b1;
        push("abort.after", T_IDLE, 0, 0, 0);
        tick();
        check32("abort.z", z, 32'h0);
        check32("abort.r2", r[2], 32'h0);
`ifdef DATAPATH_CTRL_PERF_EN
        perf_exp = 0;
        check32("abort.retired_cnt", {16'h0, rc}, 32'h0);
`endif

        // ADD R0,R1 -> R2
        run_instr("add", 2'b10, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0);
        check32("r2", r[2], 32'h30);

        // MOVE R2 -> R3 with start/opcode churn while busy
        run_instr("move", 2'b01, 2'd2, 2'd0, 2'd3, 1'b1, 1'b0);
        check32("r3_move", r[3], 32'h30);
        push("move.no_accept", T_IDLE, 0, 0, 0);
        tick();

        // Back-to-back with start held: NOP then ADD R3,R3 -> R3
        run_instr("b2b_nop", 2'b11, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1);
        run_instr("b2b_add", 2'b10, 2'd3, 2'd3, 2'd3, 1'b0, 1'b0);
        check32("r3_double", r[3], 32'h60);

        // Out-of-range destination on the NREG=3 instance
        opcode = 2'b00; ra = 2'd0; rb = 2'd0; rd = 2'd3; start3 = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clock);
            #1;
            start3 = 1'b0;
            check32($sformatf("oor.rin.c%0d", c), {29'h0, rin3}, 32'h0);
            check32($sformatf("oor.done.c%0d", c), {31'h0, done3}, (c == 2) ? 32'h1 : 32'h0);
            check32($sformatf("oor.mdr.c%0d", c), {31'h0, mdr3}, (c == 1) ? 32'h1 : 32'h0);
        end
`ifdef DATAPATH_CTRL_PERF_EN
        check32("oor.retired_cnt", {16'h0, rc3}, 32'h1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
